utf8_stream_decoder: RTL and testbench
======================================

UTF8_STREAM_DECODER -- requirements
Module: utf8_stream_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_byte  input  8  UTF-8 byte from upstream byte source.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_byte this cycle; transfer = in_valid & in_ready.
REQ-007 out_cp  output  21  decoded code point; 0x0FFFD when out_err=1.
REQ-008 out_err  output  3  error code: 0 none, 1 stray continuation, 2 invalid lead, 3 truncated, 4 overlong, 5 surrogate, 6 above 0x10FFFF.
REQ-009 out_valid  output  1  out_cp/out_err hold a token.
REQ-010 out_ready  input  1  downstream consumes the token; transfer = out_valid & out_ready.

Function
REQ-011 SHALL contain a state machine with states IDLE and CONT, a 2-bit remaining-byte counter (rem), a 2-bit sequence length (len), a 21-bit accumulator (acc) and a one-entry output register.
REQ-012 Output slot free = !out_valid | out_ready; in_ready SHALL be 0 whenever the slot is not free.
REQ-013 IDLE, accepted byte 0x00-0x7F: emit out_cp = byte, out_err = 0; stay IDLE.
REQ-014 IDLE, 0xC2-0xDF / 0xE0-0xEF / 0xF0-0xF4: load acc with payload bits (5/4/3), set len = 2/3/4 and rem = 1/2/3, go to CONT; emit nothing.
REQ-015 IDLE, 0x80-0xBF: emit error token code 1; 0xC0, 0xC1, 0xF5-0xFF: emit error token code 2; stay IDLE.
REQ-016 CONT, accepted byte 10xxxxxx: acc = {acc, byte[5:0]} truncated to 21 bits; rem decrements.
REQ-017 CONT, continuation byte with rem = 1: SHALL go to IDLE and emit a token after range checks in priority order: overlong (len=3 & acc<0x800, or len=4 & acc<0x10000) -> code 4; 0xD800-0xDFFF -> code 5; >0x10FFFF -> code 6; otherwise out_cp = acc, code 0.
REQ-018 CONT, in_valid with non-continuation byte: SHALL drive in_ready = 0 (byte not consumed), emit error token code 3 if slot free, go to IDLE; the same byte SHALL be processed as a lead in a following cycle.
REQ-019 Token latency: out_valid SHALL rise on the clock edge that accepts the final byte (or the edge of REQ-018); one token per completed or aborted sequence.
REQ-020 out_valid & !out_ready: out_cp, out_err, out_valid SHALL hold stable; state, acc and rem SHALL not change.
REQ-021 Simultaneous token drain and new token load in one cycle SHALL be supported, sustaining one byte per cycle for ASCII input.
REQ-022 in_ready SHALL not depend combinationally on in_valid except via the REQ-018 abort case.

Reset
REQ-023 rst_n = 0 SHALL immediately force state IDLE, rem = 0, len = 0, acc = 0, out_valid = 0, out_cp = 0, out_err = 0; in_ready SHALL be 1 during and after reset.
REQ-024 Reset mid-sequence SHALL discard the partial sequence without emitting any token.

Verification
REQ-025 Bytes 0x41, 0xC3 0xA9, 0xE2 0x82 0xAC, 0xF0 0x9F 0x98 0x80 back-to-back, out_ready = 1 -> tokens 0x41, 0xE9, 0x20AC, 0x1F600, all out_err = 0.
REQ-026 Bytes 0xE0 0x80 0x80 -> one token 0xFFFD code 4; 0xED 0xA0 0x80 -> 0xFFFD code 5; 0xF4 0x90 0x80 0x80 -> 0xFFFD code 6.
REQ-027 Bytes 0xC3 0x41 -> in_ready = 0 on the first presentation of 0x41, token 0xFFFD code 3, then token 0x41 code 0.
REQ-028 Bytes 0x80, 0xC0, 0xFF -> three tokens 0xFFFD with codes 1, 2, 2.
REQ-029 out_ready held 0 for 5 cycles after 0x41 is accepted -> out_valid stays 1, out_cp stays 0x41, in_ready = 0; on release, the next byte is accepted in the same cycle the token drains.
REQ-030 rst_n pulsed low after 0xE2 0x82, then 0x41 -> no token for the partial sequence; a single token 0x41, code 0.

Source files
------------

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 decoder: one byte in per transfer, one code-point or error token out per sequence.
// Latency: token registered on the edge accepting the final byte; stalls hold state and token when out_ready is low.
module utf8_stream_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [20:0] out_cp,
  output logic [2:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {IDLE, CONT} state_t;

  localparam logic [20:0] REPL_CP = 21'h0FFFD;

  state_t      state, state_nxt;
  logic [1:0]  rem, rem_nxt;
  logic [1:0]  len, len_nxt;
  logic [20:0] acc, acc_nxt;
  logic        emit;
  logic [20:0] emit_cp;
  logic [2:0]  emit_err;
  logic        slot_free;
  logic        is_cont;
  logic        abort;
  logic        take;
  logic [20:0] acc_shift;

  assign slot_free = !out_valid || out_ready;
  assign is_cont   = (in_byte[7:6] == 2'b10);
  assign abort     = (state == CONT) && in_valid && !is_cont && slot_free;
  assign in_ready  = slot_free && !abort;
  assign take      = in_valid && in_ready;
  assign acc_shift = {acc[14:0], in_byte[5:0]};

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    len_nxt   = len;
    acc_nxt   = acc;
    emit      = 1'b0;
    emit_cp   = REPL_CP;
    emit_err  = 3'd0;
    if (abort) begin
      emit      = 1'b1;
      emit_err  = 3'd3;
      state_nxt = IDLE;
      rem_nxt   = 2'd0;
    end else if (take) begin
      case (state)
        IDLE: begin
          if (!in_byte[7]) begin
            emit    = 1'b1;
            emit_cp = {13'd0, in_byte};
          end else if (in_byte >= 8'hC2 && in_byte <= 8'hDF) begin
            acc_nxt   = {16'd0, in_byte[4:0]};
            len_nxt   = 2'd2;
            rem_nxt   = 2'd1;
            state_nxt = CONT;
          end else if (in_byte >= 8'hE0 && in_byte <= 8'hEF) begin
            acc_nxt   = {17'd0, in_byte[3:0]};
            len_nxt   = 2'd3;
            rem_nxt   = 2'd2;
            state_nxt = CONT;
          end else if (in_byte >= 8'hF0 && in_byte <= 8'hF4) begin
            acc_nxt   = {18'd0, in_byte[2:0]};
            len_nxt   = 2'd0;  // four-byte length wraps to 0 in the 2-bit field
            rem_nxt   = 2'd3;
            state_nxt = CONT;
          end else begin
            emit     = 1'b1;
            emit_err = (in_byte <= 8'hBF) ? 3'd1 : 3'd2;
          end
        end
        CONT: begin
          acc_nxt = acc_shift;
          rem_nxt = rem - 2'd1;
          if (rem == 2'd1) begin
            state_nxt = IDLE;
            emit      = 1'b1;
            if ((len == 2'd3 && acc_shift < 21'h800) ||
                (len == 2'd0 && acc_shift < 21'h10000))
              emit_err = 3'd4;
            else if (acc_shift >= 21'hD800 && acc_shift <= 21'hDFFF)
              emit_err = 3'd5;
            else if (acc_shift > 21'h10FFFF)
              emit_err = 3'd6;
            else
              emit_cp = acc_shift;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 2'd0;
      len   <= 2'd0;
      acc   <= 21'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      len   <= len_nxt;
      acc   <= acc_nxt;
    end
  end

  // Load and drain may coincide: a new token simply overwrites the draining one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cp    <= 21'd0;
      out_err   <= 3'd0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_cp    <= emit_cp;
      out_err   <= emit_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Bench for utf8_stream_decoder: directed vector table, hand-written handshake sequences,
// and random byte streams scored against an array-based UTF-8 reference decoder.
module tb_utf8_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] out_cp;
  logic [2:0]  out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [20:0] exp_cp[$];
  logic [2:0]  exp_err[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          nb;
    logic [20:0] cp;
    logic [2:0]  err;
  } vec_t;

  vec_t tbl[14];

  utf8_stream_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_cp(out_cp), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void push_tok(input int cp, input int err);
    exp_cp.push_back((err == 0) ? 21'(cp) : 21'h0FFFD);
    exp_err.push_back(3'(err));
  endfunction

  // Reference decoder: walks the whole byte array; an interrupted sequence
  // yields a truncation token and the interrupting byte is decoded afresh.
  function automatic void model(input logic [7:0] q[$]);
    int i = 0;
    int n = q.size();
    while (i < n) begin
      int b = q[i];
      if (b < 'h80) begin
        push_tok(b, 0); i++;
      end else if (b < 'hC0) begin
        push_tok(0, 1); i++;
      end else if (b < 'hC2 || b >= 'hF5) begin
        push_tok(0, 2); i++;
      end else begin
        int need = (b < 'hE0) ? 2 : (b < 'hF0) ? 3 : 4;
        int cp = b % ((need == 2) ? 32 : (need == 3) ? 16 : 8);
        int k = 1;
        bit aborted = 0;
        i++;
        while (k < need && !aborted) begin
          if (i >= n) return;
          if (q[i] >= 8'h80 && q[i] <= 8'hBF) begin
            cp = cp * 64 + (q[i] % 64); i++; k++;
          end else aborted = 1;
        end
        if (aborted) push_tok(0, 3);
        else if ((need == 3 && cp < 'h800) || (need == 4 && cp < 'h10000)) push_tok(0, 4);
        else if (cp >= 'hD800 && cp <= 'hDFFF) push_tok(0, 5);
        else if (cp > 'h10FFFF) push_tok(0, 6);
        else push_tok(cp, 0);
      end
    end
  endfunction

  task automatic run_stream(input logic [7:0] q[$], input int vpct, input int rpct, output int cyc);
    int idx = 0;
    int got = 0;
    int n = q.size();
    int nexp = exp_cp.size();
    int budget = 40 * n + 50;
    cyc = 0;
    while ((idx < n || got < nexp) && cyc < budget) begin
      @(negedge clk);
      in_valid  = (idx < n) && ($urandom_range(99) < vpct);
      in_byte   = (idx < n) ? q[idx] : 8'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      #1;
      if (out_valid && out_ready) begin
        if (got < nexp)
          check("token", {8'd0, out_err, out_cp}, {8'd0, exp_err[got], exp_cp[got]});
        else
          check("extra_token", 32'(out_valid), 32'd0);
        got++;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    check("stream_done", {idx[15:0], got[15:0]}, {n[15:0], nexp[15:0]});
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("idle_after", 32'(out_valid), 32'd0);
    exp_cp.delete();
    exp_err.delete();
  endtask

  initial begin
    logic [7:0] q[$];
    int cyc;

    tbl[0]  = '{8'h41, 8'h00, 8'h00, 8'h00, 1, 21'h41,     3'd0};
    tbl[1]  = '{8'hC3, 8'hA9, 8'h00, 8'h00, 2, 21'hE9,     3'd0};
    tbl[2]  = '{8'hE2, 8'h82, 8'hAC, 8'h00, 3, 21'h20AC,   3'd0};
    tbl[3]  = '{8'hF0, 8'h9F, 8'h98, 8'h80, 4, 21'h1F600,  3'd0};
    tbl[4]  = '{8'hE0, 8'h80, 8'h80, 8'h00, 3, 21'h0FFFD,  3'd4};
    tbl[5]  = '{8'hED, 8'hA0, 8'h80, 8'h00, 3, 21'h0FFFD,  3'd5};
    tbl[6]  = '{8'hF4, 8'h90, 8'h80, 8'h80, 4, 21'h0FFFD,  3'd6};
    tbl[7]  = '{8'h80, 8'h00, 8'h00, 8'h00, 1, 21'h0FFFD,  3'd1};
    tbl[8]  = '{8'hC0, 8'h00, 8'h00, 8'h00, 1, 21'h0FFFD,  3'd2};
    tbl[9]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 1, 21'h0FFFD,  3'd2};
    tbl[10] = '{8'h7F, 8'h00, 8'h00, 8'h00, 1, 21'h7F,     3'd0};
    tbl[11] = '{8'hF4, 8'h8F, 8'hBF, 8'hBF, 4, 21'h10FFFF, 3'd0};
    tbl[12] = '{8'hEF, 8'hBF, 8'hBF, 8'h00, 3, 21'hFFFF,   3'd0};
    tbl[13] = '{8'hF0, 8'h8F, 8'hBF, 8'hBF, 4, 21'h0FFFD,  3'd4};

    // Reset state
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cp", 32'(out_cp), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single-sequence vectors
    for (int t = 0; t < 14; t++) begin
      q = {tbl[t].b0};
      if (tbl[t].nb > 1) q.push_back(tbl[t].b1);
      if (tbl[t].nb > 2) q.push_back(tbl[t].b2);
      if (tbl[t].nb > 3) q.push_back(tbl[t].b3);
      exp_cp.push_back(tbl[t].cp);
      exp_err.push_back(tbl[t].err);
      run_stream(q, 100, 100, cyc);
    end

    // Back-to-back stream at full rate: one byte per cycle plus the final drain
    q = {8'h41, 8'hC3, 8'hA9, 8'hE2, 8'h82, 8'hAC, 8'hF0, 8'h9F, 8'h98, 8'h80};
    exp_cp  = {21'h41, 21'hE9, 21'h20AC, 21'h1F600};
    exp_err = {3'd0, 3'd0, 3'd0, 3'd0};
    run_stream(q, 100, 100, cyc);
    check("full_rate_cycles", 32'(cyc), 32'd11);

    // Truncation: non-continuation after a lead is refused, then reprocessed
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'hC3; out_ready = 1'b1;
    #1;
    check("trunc_lead_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_byte = 8'h41;
    #1;
    check("trunc_refuse", 32'(in_ready), 32'd0);
    check("trunc_no_tok_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("trunc_tok", {7'd0, out_valid, out_err, out_cp}, {7'd0, 1'b1, 3'd3, 21'h0FFFD});
    check("trunc_reaccept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("trunc_ascii", {7'd0, out_valid, out_err, out_cp}, {7'd0, 1'b1, 3'd0, 21'h41});
    @(negedge clk);
    #1;
    check("trunc_drained", 32'(out_valid), 32'd0);

    // Output stall holds token and blocks input; release drains and accepts together
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'h41; out_ready = 1'b1;
    #1;
    check("stall_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_byte = 8'h42; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_cp", 32'(out_cp), 32'h41);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("release_next", {7'd0, out_valid, out_err, out_cp}, {7'd0, 1'b1, 3'd0, 21'h42});
    @(negedge clk);
    #1;
    check("release_drained", 32'(out_valid), 32'd0);

    // Reset mid-sequence discards the partial code point
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'hE2; out_ready = 1'b1;
    @(negedge clk);
    in_byte = 8'h82;
    #1;
    check("mid_no_tok", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_after_rst", 32'(out_valid), 32'd0);
    q = {8'h41};
    exp_cp.push_back(21'h41);
    exp_err.push_back(3'd0);
    run_stream(q, 100, 100, cyc);

    // Random streams against the reference decoder
    for (int s = 0; s < 4; s++) begin
      int vp = (s == 0) ? 100 : (s == 1) ? 70 : (s == 2) ? 40 : 90;
      int rp = (s == 0) ? 100 : (s == 1) ? 50 : (s == 2) ? 90 : 30;
      q = {};
      for (int k = 0; k < 150; k++) begin
        case ($urandom_range(9))
          0, 1, 2, 3: q.push_back(8'($urandom_range(127)));
          4: q.push_back(8'($urandom));
          5: begin
            q.push_back(8'(8'hC2 + $urandom_range(29)));
            q.push_back(8'(8'h80 + $urandom_range(63)));
          end
          6: begin
            q.push_back(8'(8'hE0 + $urandom_range(15)));
            for (int c = 0; c < 2; c++) q.push_back(8'(8'h80 + $urandom_range(63)));
          end
          7: begin
            q.push_back(8'(8'hF0 + $urandom_range(4)));
            for (int c = 0; c < 3; c++) q.push_back(8'(8'h80 + $urandom_range(63)));
          end
          8: begin
            q.push_back(8'(8'hE0 + $urandom_range(15)));
            q.push_back(8'(8'h80 + $urandom_range(63)));
          end
          default: q.push_back(8'(8'h80 + $urandom_range(63)));
        endcase
      end
      q.push_back(8'h41);
      model(q);
      run_stream(q, vp, rp, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
